// File: rtl/vram_fill_pkg.sv
// Shared types and helpers for the VRAM Avalon fill master.
// Contents:
//   fill_state_t    - fill sequencer states
//   VRAM_WORDS_C    - words in the text/track VRAM window
//   PALETTE_SEL_BIT - address bit selecting the palette range (never driven high)
//   byte_masked_eq  - compares two words on the enabled byte lanes only
package vram_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        NEXT,
        FINISH
    } fill_state_t;

    localparam int unsigned VRAM_WORDS_C    = 512;
    localparam int unsigned PALETTE_SEL_BIT = 9;

    function automatic logic byte_masked_eq(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  be);
        logic eq;
        eq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (be[i] && (a[8*i +: 8] != b[8*i +: 8])) begin
                eq = 1'b0;
            end
        end
        return eq;
    endfunction

endpackage

// File: rtl/vram_fill_addr_ctr.sv
// Wrapping word-address counter plus remaining-word down-counter.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   load_i         - load start address (wrapped into the window) and word count
//   step_i         - advance address (mod VRAM_WORDS) and decrement remaining count
//   load_addr_i    - start address
//   load_count_i   - number of words
//   addr_nxt_o     - address the counter will hold after this edge
//   zero_o         - remaining count is zero
module vram_fill_addr_ctr
    import vram_fill_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned VRAM_WORDS = VRAM_WORDS_C
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [9:0]        load_count_i,
    output logic [ADDR_W-1:0] addr_nxt_o,
    output logic              zero_o
);

    // VRAM_WORDS is a power of two, so masking gives the modulo wrap.
    localparam logic [ADDR_W-1:0] WrapMask = ADDR_W'(VRAM_WORDS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = load_addr_i & WrapMask;
            rem_d  = load_count_i;
        end else if (step_i) begin
            addr_d = (addr_q + 1'b1) & WrapMask;
            rem_d  = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_nxt_o = addr_d;
    assign zero_o     = (rem_q == 10'd0);

endmodule

// File: rtl/vram_avl_fill_master.sv
// Avalon-MM master that block-fills VRAM words, optionally reading each word
// back and counting byte-masked mismatches.
// Ports:
//   CLK, RESET_N          - clock, asynchronous active-low reset
//   START                 - command strobe, accepted only when idle
//   START_ADDR/WORD_COUNT - first word and number of words (0..512)
//   PATTERN/FILL_BE       - fill data and byte enables for every write
//   VERIFY                - read back and compare each written word
//   BUSY/DONE/ERR_COUNT   - status; ERR_COUNT holds until the next START
//   AVM_*                 - Avalon master towards the VRAM slave port
// Build option: VRAM_FILL_INCR_EN adds PATTERN_STEP; word k is written with
// PATTERN + k*PATTERN_STEP.
module vram_avl_fill_master
    import vram_fill_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned VRAM_WORDS = VRAM_WORDS_C,
    parameter int unsigned READ_WAIT  = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [9:0]        WORD_COUNT,
    input  logic [DATA_W-1:0] PATTERN,
`ifdef VRAM_FILL_INCR_EN
    input  logic [DATA_W-1:0] PATTERN_STEP,
`endif
    input  logic [3:0]        FILL_BE,
    input  logic              VERIFY,
    output logic              BUSY,
    output logic              DONE,
    output logic [9:0]        ERR_COUNT,
    output logic              AVM_CS,
    output logic              AVM_WRITE,
    output logic              AVM_READ,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic [3:0]        AVM_BYTE_EN,
    output logic [DATA_W-1:0] AVM_WRITEDATA,
    input  logic [DATA_W-1:0] AVM_READDATA
);

    localparam logic [7:0] RdLast = 8'(READ_WAIT);

    fill_state_t       state_q, state_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic [3:0]        be_q, be_d;
    logic              verify_q, verify_d;
    logic [9:0]        err_q, err_d;
`ifdef VRAM_FILL_INCR_EN
    logic [DATA_W-1:0] step_q, step_d;
`endif

    logic              start_acc, ctr_step, ctr_zero;
    logic [ADDR_W-1:0] ctr_addr_nxt;

    // Output registers, loaded from the next state so strobes align with it.
    logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        byte_en_q, byte_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign start_acc = (state_q == IDLE) && START;
    // Address/pattern advance on entry to NEXT, so NEXT already sees the new word.
    assign ctr_step  = (state_d == NEXT) && (state_q != NEXT);

    vram_fill_addr_ctr #(
        .ADDR_W     (ADDR_W),
        .VRAM_WORDS (VRAM_WORDS)
    ) u_addr_ctr (
        .clk_i        (CLK),
        .rst_ni       (RESET_N),
        .load_i       (start_acc),
        .step_i       (ctr_step),
        .load_addr_i  (START_ADDR),
        .load_count_i (WORD_COUNT),
        .addr_nxt_o   (ctr_addr_nxt),
        .zero_o       (ctr_zero)
    );

    // State register (plus command/datapath registers).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            pat_q     <= '0;
            be_q      <= '0;
            verify_q  <= 1'b0;
            err_q     <= '0;
`ifdef VRAM_FILL_INCR_EN
            step_q    <= '0;
`endif
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            byte_en_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            pat_q     <= pat_d;
            be_q      <= be_d;
            verify_q  <= verify_d;
            err_q     <= err_d;
`ifdef VRAM_FILL_INCR_EN
            step_q    <= step_d;
`endif
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            byte_en_q <= byte_en_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = (WORD_COUNT == 10'd0) ? FINISH : WR;
            WR:      state_d = verify_q ? RD : NEXT;
            RD:      if (rd_cnt_q == RdLast) state_d = NEXT;
            NEXT:    state_d = ctr_zero ? FINISH : WR;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, pattern accumulation, read-wait count and error count.
    always_comb begin
        be_d     = start_acc ? FILL_BE : be_q;
        verify_d = start_acc ? VERIFY : verify_q;
        rd_cnt_d = (state_q == RD && state_d == RD) ? rd_cnt_q + 8'd1 : 8'd0;
        pat_d    = pat_q;
`ifdef VRAM_FILL_INCR_EN
        step_d   = start_acc ? PATTERN_STEP : step_q;
        if (start_acc)     pat_d = PATTERN;
        else if (ctr_step) pat_d = pat_q + step_q;
`else
        if (start_acc)     pat_d = PATTERN;
`endif
        err_d = err_q;
        if (start_acc) begin
            err_d = '0;
        end else if (state_q == RD && rd_cnt_q == RdLast &&
                     !byte_masked_eq(AVM_READDATA, pat_q, be_q) && err_q != 10'h3FF) begin
            err_d = err_q + 10'd1;
        end
    end

    // Output logic.
    always_comb begin
        wr_d   = (state_d == WR);
        rd_d   = (state_d == RD);
        cs_d   = wr_d || rd_d;
        busy_d = cs_d || (state_d == NEXT);
        done_d = (state_d == FINISH);
        addr_d = '0;
        if (cs_d) begin
            addr_d                  = ctr_addr_nxt;
            addr_d[PALETTE_SEL_BIT] = 1'b0;
        end
        byte_en_d = wr_d ? be_d : (rd_d ? 4'hF : 4'h0);
        wdata_d   = wr_d ? pat_d : '0;
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR_COUNT     = err_q;
    assign AVM_CS        = cs_q;
    assign AVM_WRITE     = wr_q;
    assign AVM_READ      = rd_q;
    assign AVM_ADDR      = addr_q;
    assign AVM_BYTE_EN   = byte_en_q;
    assign AVM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_vram_avl_fill_master.sv
// Self-checking bench for vram_avl_fill_master: slave memory model with
// programmable read corruption, per-cycle bus comparison against a reference
// trace computed from word count, verify mode and read wait states.
module tb_vram_avl_fill_master;

    localparam int unsigned RW = 1;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        START = 1'b0;
    logic [9:0]  START_ADDR = '0;
    logic [9:0]  WORD_COUNT = '0;
    logic [31:0] PATTERN = '0;
    logic [31:0] PATTERN_STEP = '0;
    logic [3:0]  FILL_BE = '0;
    logic        VERIFY = 1'b0;
    logic        BUSY, DONE, AVM_CS, AVM_WRITE, AVM_READ;
    logic [9:0]  ERR_COUNT, AVM_ADDR;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA, AVM_READDATA;

    logic [31:0] mem [512];
    int unsigned rd_age;
    logic [9:0]  corrupt_addr = 10'h3FF;
    logic [3:0]  corrupt_mask = 4'h0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    vram_avl_fill_master #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .VRAM_WORDS (512),
        .READ_WAIT  (RW)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .START         (START),
        .START_ADDR    (START_ADDR),
        .WORD_COUNT    (WORD_COUNT),
        .PATTERN       (PATTERN),
`ifdef VRAM_FILL_INCR_EN
        .PATTERN_STEP  (PATTERN_STEP),
`endif
        .FILL_BE       (FILL_BE),
        .VERIFY        (VERIFY),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR_COUNT     (ERR_COUNT),
        .AVM_CS        (AVM_CS),
        .AVM_WRITE     (AVM_WRITE),
        .AVM_READ      (AVM_READ),
        .AVM_ADDR      (AVM_ADDR),
        .AVM_BYTE_EN   (AVM_BYTE_EN),
        .AVM_WRITEDATA (AVM_WRITEDATA),
        .AVM_READDATA  (AVM_READDATA)
    );

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Slave: byte-enabled writes, read data valid only in the last wait cycle.
    always @(posedge CLK) begin
        if (AVM_WRITE) begin
            mem[AVM_ADDR[8:0]] <= (mem[AVM_ADDR[8:0]] & ~lane_mask(AVM_BYTE_EN)) |
                                  (AVM_WRITEDATA & lane_mask(AVM_BYTE_EN));
        end
    end

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rd_age <= 0;
        else          rd_age <= AVM_READ ? rd_age + 1 : 0;
    end

    always_comb begin
        AVM_READDATA = ~mem[AVM_ADDR[8:0]];
        if (AVM_READ && rd_age == RW) begin
            AVM_READDATA = mem[AVM_ADDR[8:0]];
            if (AVM_ADDR == corrupt_addr) AVM_READDATA = AVM_READDATA ^ lane_mask(corrupt_mask);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and compare every bus cycle against the reference trace.
    // poke: 0 none, -1 random cycle, >0 cycle in which a stray START is driven.
    task automatic run_cmd(input int saddr, input int n, input logic [31:0] pat,
                           input logic [31:0] step, input logic [3:0] be, input logic ver,
                           input int poke);
        int          per, len, k, p, a, exp_err, bad, pk;
        logic [31:0] eff_step, wdat;
        logic        e_cs, e_wr, e_rd, e_busy, e_done;
        logic [9:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_data;
        logic [63:0] obs, exp;
`ifdef VRAM_FILL_INCR_EN
        eff_step = step;
`else
        eff_step = 32'h0;
`endif
        per = ver ? 3 + RW : 2;
        len = 1 + n * per;
        pk  = (poke < 0) ? int'($urandom_range(1, len)) : poke;
        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            a = ((saddr % 512) + i) % 512;
            if (ver && 10'(a) == corrupt_addr && (corrupt_mask & be) != 4'h0) exp_err++;
        end

        @(negedge CLK);
        START = 1'b1; START_ADDR = 10'(saddr); WORD_COUNT = 10'(n);
        PATTERN = pat; PATTERN_STEP = step; FILL_BE = be; VERIFY = ver;
        @(negedge CLK);
        for (int c = 1; c <= len + 1; c++) begin
            e_cs = 0; e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0;
            e_addr = '0; e_be = '0; e_data = '0;
            if (c == len) begin
                e_done = 1;
            end else if (c < len) begin
                e_busy = 1;
                k = (c - 1) / per;
                p = (c - 1) % per;
                e_addr = 10'(((saddr % 512) + k) % 512);
                if (p == 0) begin
                    e_cs = 1; e_wr = 1; e_be = be; e_data = pat + 32'(k) * eff_step;
                end else if (ver && p <= RW + 1) begin
                    e_cs = 1; e_rd = 1; e_be = 4'hF;
                end
            end
            if (!e_cs) e_addr = '0;
            obs = {12'h0, AVM_ADDR[9], AVM_CS, AVM_WRITE, AVM_READ, BUSY, DONE,
                   AVM_CS ? AVM_ADDR : 10'h0, AVM_CS ? AVM_BYTE_EN : 4'h0,
                   AVM_WRITE ? AVM_WRITEDATA : 32'h0};
            exp = {12'h0, 1'b0, e_cs, e_wr, e_rd, e_busy, e_done, e_addr, e_be, e_data};
            check($sformatf("bus a=%0h n=%0d v=%0d cyc%0d", saddr, n, ver, c), obs, exp);
            if (c >= len) check($sformatf("err_count cyc%0d", c), 64'(ERR_COUNT), 64'(exp_err));
            // Command inputs are scrambled after START; the DUT must use latched copies.
            START = (c == pk); START_ADDR = 10'($urandom); WORD_COUNT = 10'($urandom_range(1, 8));
            PATTERN = $urandom; PATTERN_STEP = $urandom; FILL_BE = 4'($urandom);
            VERIFY = 1'($urandom);
            @(negedge CLK);
        end
        START = 1'b0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = ((saddr % 512) + i) % 512;
            wdat = pat + 32'(i) * eff_step;
            if ((mem[a] & lane_mask(be)) != (wdat & lane_mask(be))) bad++;
        end
        check($sformatf("mem a=%0h n=%0d", saddr, n), 64'(bad), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sa, n;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {AVM_CS, AVM_WRITE, AVM_READ, BUSY, DONE, AVM_ADDR, AVM_BYTE_EN,
                                AVM_WRITEDATA, ERR_COUNT}, 64'h0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Basic fill, wrap across the top of the window, no verify.
        run_cmd(32'h010, 4, 32'hA5A5_A5A5, 32'h1, 4'hF, 1'b0, 0);
        run_cmd(32'h1FE, 4, 32'h1234_5678, 32'h0, 4'hF, 1'b0, 0);

        // Verify with byte 0 of word 2 corrupted, then with byte 0 disabled.
        corrupt_addr = 10'h042; corrupt_mask = 4'h1;
        run_cmd(32'h040, 5, 32'h5A5A_C3C3, 32'h0, 4'hF, 1'b1, 0);
        check("err_one", 64'(ERR_COUNT), 64'd1);
        run_cmd(32'h040, 5, 32'h5A5A_C3C3, 32'h0, 4'hE, 1'b1, 0);
        check("err_zero", 64'(ERR_COUNT), 64'd0);

        // Zero words with START during DONE; stray START while busy.
        run_cmd(32'h100, 0, 32'hFFFF_0000, 32'h0, 4'hF, 1'b1, 1);
        run_cmd(32'h080, 3, 32'h0BAD_F00D, 32'h0, 4'h5, 1'b0, 3);
        run_cmd(32'h090, 2, 32'hCAFE_0001, 32'h0, 4'hF, 1'b1, 9);
        corrupt_addr = 10'h3FF; corrupt_mask = 4'h0;

        // Reset in the middle of a 100-word fill.
        @(negedge CLK);
        START = 1'b1; START_ADDR = 10'h100; WORD_COUNT = 10'd100; PATTERN = 32'h7777_7777;
        FILL_BE = 4'hF; VERIFY = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (36) @(negedge CLK);
        check("write_before_reset", {63'h0, AVM_WRITE}, 64'h1);
        #2 RESET_N = 1'b0;
        #1 check("reset_async", {59'h0, AVM_CS, AVM_WRITE, AVM_READ, BUSY, DONE}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("reset_no_done", {62'h0, DONE, BUSY}, 64'h0);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        check("after_reset_idle", {59'h0, AVM_CS, AVM_WRITE, AVM_READ, BUSY, DONE}, 64'h0);
        run_cmd(32'h0F0, 3, 32'h0102_0304, 32'h0, 4'hF, 1'b1, 0);

`ifdef VRAM_FILL_INCR_EN
        run_cmd(32'h020, 3, 32'hFFFF_FFFE, 32'h1, 4'hF, 1'b0, 0);
        corrupt_addr = 10'h031; corrupt_mask = 4'h8;
        run_cmd(32'h030, 4, 32'h1000_0000, 32'h0101_0101, 4'hF, 1'b1, 0);
        corrupt_addr = 10'h3FF; corrupt_mask = 4'h0;
`endif

        // Randomized commands (bit 9 of START_ADDR must be ignored).
        for (int it = 0; it < 24; it++) begin
            sa = int'($urandom_range(0, 1023));
            n  = int'($urandom_range(0, 10));
            corrupt_addr = 10'(((sa % 512) + int'($urandom_range(0, 10))) % 512);
            corrupt_mask = 4'($urandom);
            run_cmd(sa, n, $urandom, $urandom, 4'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? -1 : 0);
        end
        corrupt_addr = 10'h3FF; corrupt_mask = 4'h0;

        // Full window.
        run_cmd(32'h155, 512, $urandom, 32'h3, 4'hF, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
